// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I subset decoder with ID/EX, EX/MEM, MEM/WB control pipeline
// Also resolves load-use stalls, branch flushes and EX-stage forwarding selects.
module pipelined_control_unit #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1,
   parameter bit HAZARD_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [XLEN-1:0]       instr_i,
   input  logic                  instr_valid_i,
   input  logic                  branch_taken_i,
   output logic                  ex_alusrc_o,
   output logic [1:0]            ex_aluop_o,
   output logic                  ex_branch_o,
   output logic                  ex_bne_o,
   output logic [REG_ADDR_W-1:0] ex_rs1_o,
   output logic [REG_ADDR_W-1:0] ex_rs2_o,
   output logic [REG_ADDR_W-1:0] ex_rd_o,
   output logic                  mem_memread_o,
   output logic                  mem_memwrite_o,
   output logic [REG_ADDR_W-1:0] mem_rd_o,
   output logic                  mem_regwrite_o,
   output logic                  wb_regwrite_o,
   output logic                  wb_memtoreg_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic [1:0]            forward_a_o,
   output logic [1:0]            forward_b_o,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  illegal_o
);

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic                  alusrc;
      logic                  memtoreg;
      logic                  regwrite;
      logic                  memread;
      logic                  memwrite;
      logic                  branch;
      logic [1:0]            aluop;
      logic                  bne;
      logic                  illegal;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
   } idex_t;

   typedef struct packed {
      logic                  memread;
      logic                  memwrite;
      logic                  regwrite;
      logic                  memtoreg;
      logic [REG_ADDR_W-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic                  regwrite;
      logic                  memtoreg;
      logic [REG_ADDR_W-1:0] rd;
   } memwb_t;

   idex_t  ex_q,  ex_d,  dec;
   exmem_t mem_q, mem_d;
   memwb_t wb_q,  wb_d;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
   logic                  rs2_used, id_legal, load_use, stall;
   logic [XLEN-1:25]      unused_instr_bits;

   assign opcode            = instr_i[6:0];
   assign funct3            = instr_i[14:12];
   assign id_rd             = REG_ADDR_W'(instr_i[11:7]);
   assign id_rs1            = REG_ADDR_W'(instr_i[19:15]);
   assign id_rs2            = REG_ADDR_W'(instr_i[24:20]);
   assign unused_instr_bits = instr_i[XLEN-1:25];

   // Unknown encodings fall through with every field zero so nothing X reaches EX.
   always_comb begin
      dec      = '0;
      rs2_used = 1'b0;
      if (instr_valid_i) begin
         case (opcode)
            OP_LW:    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                       dec.memwrite, dec.branch, dec.aluop} = 8'b1111_0000;
            OP_SW: begin
               {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                dec.memwrite, dec.branch, dec.aluop} = 8'b1000_1000;
               rs2_used = 1'b1;
            end
            OP_RTYPE: begin
               {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                dec.memwrite, dec.branch, dec.aluop} = 8'b0010_0010;
               rs2_used = 1'b1;
            end
            OP_ADDI:  {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                       dec.memwrite, dec.branch, dec.aluop} = 8'b1010_0000;
            OP_BRANCH: begin
               if (funct3[2:1] == 2'b00) begin
                  {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                   dec.memwrite, dec.branch, dec.aluop} = 8'b0000_0101;
                  dec.bne  = funct3[0];
                  rs2_used = 1'b1;
               end else begin
                  dec.illegal = 1'b1;
               end
            end
            default:  dec.illegal = 1'b1;
         endcase
      end
      id_legal = instr_valid_i && !dec.illegal;
      dec.rs1  = id_legal ? id_rs1 : '0;
      dec.rs2  = rs2_used ? id_rs2 : '0;
      dec.rd   = dec.regwrite ? id_rd : '0;
   end

   always_comb begin
      load_use = ex_q.memread && (ex_q.rd != '0) && id_legal &&
                 ((ex_q.rd == id_rs1) || (rs2_used && (ex_q.rd == id_rs2)));
      stall    = HAZARD_EN && load_use && !branch_taken_i;
   end

   // A stall or a flush both turn the ID/EX slot into a bubble; later stages keep flowing.
   always_comb begin
      ex_d           = (stall || branch_taken_i) ? '0 : dec;
      mem_d          = '0;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.rd       = ex_q.rd;
      wb_d           = '0;
      wb_d.regwrite  = mem_q.regwrite;
      wb_d.memtoreg  = mem_q.memtoreg;
      wb_d.rd        = mem_q.rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // EX/MEM is checked first so the younger result wins when both stages match.
   always_comb begin
      forward_a_o = 2'b00;
      forward_b_o = 2'b00;
      if (FWD_EN) begin
         if (mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1))
            forward_a_o = 2'b10;
         else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1))
            forward_a_o = 2'b01;
         if (mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2))
            forward_b_o = 2'b10;
         else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs2))
            forward_b_o = 2'b01;
      end
   end

   assign ex_alusrc_o    = ex_q.alusrc;
   assign ex_aluop_o     = ex_q.aluop;
   assign ex_branch_o    = ex_q.branch;
   assign ex_bne_o       = ex_q.bne;
   assign ex_rs1_o       = ex_q.rs1;
   assign ex_rs2_o       = ex_q.rs2;
   assign ex_rd_o        = ex_q.rd;
   assign illegal_o      = ex_q.illegal;
   assign mem_memread_o  = mem_q.memread;
   assign mem_memwrite_o = mem_q.memwrite;
   assign mem_rd_o       = mem_q.rd;
   assign mem_regwrite_o = mem_q.regwrite;
   assign wb_regwrite_o  = wb_q.regwrite;
   assign wb_memtoreg_o  = wb_q.memtoreg;
   assign wb_rd_o        = wb_q.rd;
   assign stall_o        = stall;
   assign flush_o        = branch_taken_i && rst_n;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed-vector bench for pipelined_control_unit
// A second instance with HAZARD_EN=0 shares the stimulus and is only observed on stall_o.
module tb_pipelined_control_unit;

   logic        clk, rst_n, valid, bt;
   logic [31:0] instr;

   logic       ex_alusrc, ex_branch, ex_bne, mem_memread, mem_memwrite, mem_regwrite;
   logic       wb_regwrite, wb_memtoreg, stall, flush, illegal;
   logic [1:0] ex_aluop, fwd_a, fwd_b;
   logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;

   logic       n_alusrc, n_branch, n_bne, n_memread, n_memwrite, n_mregwrite;
   logic       n_wregwrite, n_memtoreg, n_stall, n_flush, n_illegal;
   logic [1:0] n_aluop, n_fwd_a, n_fwd_b;
   logic [4:0] n_rs1, n_rs2, n_rd, n_mem_rd, n_wb_rd;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] LW5      = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
   localparam logic [31:0] LW0      = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
   localparam logic [31:0] ADD6_5_7 = {7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] ADD6_7_5 = {7'd0, 5'd5, 5'd7, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] ADDI6_1_5 = {12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011};
   localparam logic [31:0] ADD3_1_2 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
   localparam logic [31:0] ADDI4_3_1 = {12'd1, 5'd3, 3'b000, 5'd4, 7'b0010011};
   localparam logic [31:0] SUB8_3_3 = {7'b0100000, 5'd3, 5'd3, 3'b000, 5'd8, 7'b0110011};
   localparam logic [31:0] ADDI0_1_5 = {12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011};
   localparam logic [31:0] ADD9_0_0 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd9, 7'b0110011};
   localparam logic [31:0] ADDI10_0_1 = {12'd1, 5'd0, 3'b000, 5'd10, 7'b0010011};
   localparam logic [31:0] ADDI10_10_1 = {12'd1, 5'd10, 3'b000, 5'd10, 7'b0010011};
   localparam logic [31:0] ADD11_10_10 = {7'd0, 5'd10, 5'd10, 3'b000, 5'd11, 7'b0110011};
   localparam logic [31:0] BEQ      = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
   localparam logic [31:0] BNE      = {7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011};
   localparam logic [31:0] BLT      = {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
   localparam logic [31:0] ILL      = 32'h0000_007F;

   pipelined_control_unit dut (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
      .branch_taken_i(bt), .ex_alusrc_o(ex_alusrc), .ex_aluop_o(ex_aluop),
      .ex_branch_o(ex_branch), .ex_bne_o(ex_bne), .ex_rs1_o(ex_rs1),
      .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .mem_memread_o(mem_memread),
      .mem_memwrite_o(mem_memwrite), .mem_rd_o(mem_rd), .mem_regwrite_o(mem_regwrite),
      .wb_regwrite_o(wb_regwrite), .wb_memtoreg_o(wb_memtoreg), .wb_rd_o(wb_rd),
      .forward_a_o(fwd_a), .forward_b_o(fwd_b), .stall_o(stall), .flush_o(flush),
      .illegal_o(illegal)
   );

   pipelined_control_unit #(.HAZARD_EN(1'b0)) dut_nh (
      .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid),
      .branch_taken_i(bt), .ex_alusrc_o(n_alusrc), .ex_aluop_o(n_aluop),
      .ex_branch_o(n_branch), .ex_bne_o(n_bne), .ex_rs1_o(n_rs1),
      .ex_rs2_o(n_rs2), .ex_rd_o(n_rd), .mem_memread_o(n_memread),
      .mem_memwrite_o(n_memwrite), .mem_rd_o(n_mem_rd), .mem_regwrite_o(n_mregwrite),
      .wb_regwrite_o(n_wregwrite), .wb_memtoreg_o(n_memtoreg), .wb_rd_o(n_wb_rd),
      .forward_a_o(n_fwd_a), .forward_b_o(n_fwd_b), .stall_o(n_stall), .flush_o(n_flush),
      .illegal_o(n_illegal)
   );

   logic any_out;
   assign any_out = |{ex_alusrc, ex_aluop, ex_branch, ex_bne, ex_rs1, ex_rs2, ex_rd,
                      mem_memread, mem_memwrite, mem_rd, mem_regwrite, wb_regwrite,
                      wb_memtoreg, wb_rd, fwd_a, fwd_b, stall, flush, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] i, input logic v, input logic b);
      instr = i;
      valid = v;
      bt    = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      put(32'd0, 1'b0, 1'b0);
      #2;
      check("reset_all_zero", 32'(any_out), 32'd0);
      tick;
      tick;
      rst_n = 1'b1;

      // lw x5 timing through all stages, then load-use with add x6,x5,x7
      put(LW5, 1'b1, 1'b0);
      #1 check("lw_no_stall", 32'(stall), 32'd0);
      tick;
      check("lw_ex_alusrc", 32'(ex_alusrc), 32'd1);
      check("lw_ex_aluop", 32'(ex_aluop), 32'd0);
      check("lw_ex_rd", 32'(ex_rd), 32'd5);
      check("lw_ex_rs1", 32'(ex_rs1), 32'd1);
      check("lw_ex_rs2_zero", 32'(ex_rs2), 32'd0);
      put(ADD6_5_7, 1'b1, 1'b0);
      #1 check("lu_stall", 32'(stall), 32'd1);
      check("lu_nohaz_stall", 32'(n_stall), 32'd0);
      check("lu_flush", 32'(flush), 32'd0);
      tick;
      check("lu_bubble_rd", 32'(ex_rd), 32'd0);
      check("lu_bubble_rs1", 32'(ex_rs1), 32'd0);
      check("lu_bubble_aluop", 32'(ex_aluop), 32'd0);
      check("lw_mem_memread", 32'(mem_memread), 32'd1);
      check("lw_mem_rd", 32'(mem_rd), 32'd5);
      check("lu_stall_once", 32'(stall), 32'd0);
      tick;
      check("lu_add_ex_rd", 32'(ex_rd), 32'd6);
      check("lu_add_aluop", 32'(ex_aluop), 32'd2);
      check("lu_fwd_a", 32'(fwd_a), 32'd1);
      check("lu_fwd_b", 32'(fwd_b), 32'd0);
      check("lw_wb_regwrite", 32'(wb_regwrite), 32'd1);
      check("lw_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
      check("lw_wb_rd", 32'(wb_rd), 32'd5);

      // forwarding chain add x3 / addi x4,x3 / sub x8,x3,x3
      put(ADD3_1_2, 1'b1, 1'b0);
      tick;
      put(ADDI4_3_1, 1'b1, 1'b0);
      tick;
      check("addi_fwd_a", 32'(fwd_a), 32'd2);
      check("addi_fwd_b", 32'(fwd_b), 32'd0);
      check("addi_alusrc", 32'(ex_alusrc), 32'd1);
      put(SUB8_3_3, 1'b1, 1'b0);
      tick;
      check("sub_fwd_a", 32'(fwd_a), 32'd1);
      check("sub_fwd_b", 32'(fwd_b), 32'd1);

      // x0 is never a forwarding source
      put(ADDI0_1_5, 1'b1, 1'b0);
      tick;
      put(ADD9_0_0, 1'b1, 1'b0);
      tick;
      check("x0_fwd_a", 32'(fwd_a), 32'd0);
      check("x0_fwd_b", 32'(fwd_b), 32'd0);

      // both stages write x10: EX/MEM wins
      put(ADDI10_0_1, 1'b1, 1'b0);
      tick;
      put(ADDI10_10_1, 1'b1, 1'b0);
      tick;
      put(ADD11_10_10, 1'b1, 1'b0);
      tick;
      check("prio_fwd_a", 32'(fwd_a), 32'd2);
      check("prio_fwd_b", 32'(fwd_b), 32'd2);

      // lw x0 never stalls
      put(LW0, 1'b1, 1'b0);
      tick;
      put(ADD9_0_0, 1'b1, 1'b0);
      #1 check("x0_no_stall", 32'(stall), 32'd0);
      tick;

      // rs2 hazard, rs2 field of addi ignored, flush priority
      put(LW5, 1'b1, 1'b0);
      tick;
      put(ADD6_7_5, 1'b1, 1'b0);
      #1 check("rs2_stall", 32'(stall), 32'd1);
      check("rs2_nohaz_stall", 32'(n_stall), 32'd0);
      put(ADDI6_1_5, 1'b1, 1'b0);
      #1 check("addi_imm_no_stall", 32'(stall), 32'd0);
      put(ADD6_5_7, 1'b1, 1'b1);
      #1 check("flush_stall", 32'(stall), 32'd0);
      check("flush_flag", 32'(flush), 32'd1);
      tick;
      bt = 1'b0;
      check("flush_bubble_rd", 32'(ex_rd), 32'd0);
      check("flush_bubble_rs1", 32'(ex_rs1), 32'd0);
      check("flush_bubble_aluop", 32'(ex_aluop), 32'd0);

      // illegal and branch decode
      put(ILL, 1'b1, 1'b0);
      tick;
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_alusrc", 32'(ex_alusrc), 32'd0);
      check("ill_aluop", 32'(ex_aluop), 32'd0);
      check("ill_rs1", 32'(ex_rs1), 32'd0);
      put(BEQ, 1'b1, 1'b0);
      tick;
      check("ill_one_cycle", 32'(illegal), 32'd0);
      check("beq_branch", 32'(ex_branch), 32'd1);
      check("beq_bne", 32'(ex_bne), 32'd0);
      check("beq_aluop", 32'(ex_aluop), 32'd1);
      check("beq_rs2", 32'(ex_rs2), 32'd2);
      put(BNE, 1'b1, 1'b0);
      tick;
      check("bne_bne", 32'(ex_bne), 32'd1);
      check("bne_branch", 32'(ex_branch), 32'd1);
      put(BLT, 1'b1, 1'b0);
      tick;
      check("blt_illegal", 32'(illegal), 32'd1);
      check("blt_branch", 32'(ex_branch), 32'd0);
      put(LW5, 1'b0, 1'b0);
      tick;
      check("invalid_illegal", 32'(illegal), 32'd0);
      check("invalid_alusrc", 32'(ex_alusrc), 32'd0);
      check("invalid_rd", 32'(ex_rd), 32'd0);

      // reset asserted mid-stream with lw in EX
      put(LW5, 1'b1, 1'b0);
      tick;
      check("pre_rst_alusrc", 32'(ex_alusrc), 32'd1);
      rst_n = 1'b0;
      put(LW5, 1'b1, 1'b1);
      #1 check("midrst_all_zero", 32'(any_out), 32'd0);
      tick;
      rst_n = 1'b1;
      put(ADDI4_3_1, 1'b1, 1'b0);
      tick;
      check("post_rst_alusrc", 32'(ex_alusrc), 32'd1);
      check("post_rst_aluop", 32'(ex_aluop), 32'd0);
      check("post_rst_rd", 32'(ex_rd), 32'd4);
      check("post_rst_mem_memread", 32'(mem_memread), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised successor to the single-cycle opcode decoder for the 5-stage RISC-V core (RV32I subset: lw, sw, addi, R-type, beq, bne). It decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble) and branch-taken flushes, and generates EX-stage forwarding selects. Unsupported encodings decode to a safe all-zero bundle with an illegal flag, never X.

Parameters:
XLEN, 32, instruction width; must be >= 32.
REG_ADDR_W, 5, register index width.
FWD_EN, 1, 1 = forwarding selects active; 0 = forward_a_o/forward_b_o tied to 2'b00.
HAZARD_EN, 1, 1 = load-use stall active; 0 = stall_o tied to 0, so software schedules loads.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_i  in  XLEN  instruction currently in ID.
instr_valid_i  in  1  ID holds a real instruction; 0 = decode as bubble.
branch_taken_i  in  1  EX resolved a taken branch this cycle.
ex_alusrc_o  out  1  EX: ALU operand B is the immediate.
ex_aluop_o  out  2  EX: ALUOp (00 add, 01 branch compare, 10 R-type/funct).
ex_branch_o  out  1  EX: instruction is a branch.
ex_bne_o  out  1  EX: branch is bne (funct3=001).
ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_ADDR_W  EX register indices.
mem_memread_o, mem_memwrite_o  out  1  MEM control.
mem_rd_o  out  REG_ADDR_W  MEM destination register.
mem_regwrite_o  out  1  MEM RegWrite, for forwarding.
wb_regwrite_o, wb_memtoreg_o  out  1  WB control.
wb_rd_o  out  REG_ADDR_W  WB destination register.
forward_a_o, forward_b_o  out  2  00 register file, 10 EX/MEM, 01 MEM/WB.
stall_o  out  1  hold PC and IF/ID (combinational).
flush_o  out  1  clear IF/ID (combinational, equals branch_taken_i).
illegal_o  out  1  registered; pulses one cycle with the illegal instruction's EX cycle.

Behaviour:
- Decode (combinational, ID). Bundle is {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}:
  - opcode 0000011 (lw): 11110000
  - 0100011 (sw): 10001000
  - 0110011 (R-type): 00100010
  - 0010011 (addi): 10100000
  - 1100011 with funct3 000/001: 00000101; bne flag = funct3[0]
  - anything else, including branch funct3 other than 000/001: 00000000 with illegal=1
- instr_valid_i=0: bundle 0, illegal=0.
- Source usage: rs1 is used by all legal opcodes. rs2 is used by R, S and B only. For lw/addi, ex_rs2_o is loaded with 0.
- Latency: an instruction in ID at cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3.
- Load-use hazard (HAZARD_EN=1): stall_o=1 when all of the following hold:
  - EX MemRead=1 and ex_rd_o!=0;
  - ex_rd_o equals ID rs1, or equals ID rs2 when rs2 is used;
  - ID instruction is valid and legal.
- Stall effect: ID/EX loads a bubble (all control 0, indices 0). EX/MEM and MEM/WB advance normally.
- Flush: branch_taken_i=1 loads a bubble into ID/EX and drives flush_o=1. Flush has priority: stall_o is forced 0 in a flush cycle.
- Forwarding for A (rs1); B is identical using rs2:
  - 10 if mem_regwrite_o && mem_rd_o!=0 && mem_rd_o==ex_rs1_o;
  - else 01 if wb_regwrite_o && wb_rd_o!=0 && wb_rd_o==ex_rs1_o;
  - else 00. EX/MEM wins when both stages match.
- x0: never forwarded, never causes a stall.
- Reset (async assert, synchronous-release assumption on rst_n deassert): every pipeline register clears to 0. All outputs are 0 and forward selects are 00 while rst_n=0. An assertion mid-stream discards all in-flight instructions.
- State: the three pipeline registers hold everything; there is no other FSM. A stall lasts exactly one cycle per load-use pair, because the bubble clears the EX MemRead condition.

Test Plan:
- Reset: rst_n=0 mid-stream with lw in EX -> all outputs 0 immediately (before the next clk edge); after release, first addi appears on ex_* one cycle later with ex_alusrc_o=1, ex_aluop_o=00.
- Pipeline timing: lw x5,0(x1) at cycle 0 -> ex_alusrc_o=1 at cycle 1; mem_memread_o=1, mem_rd_o=5 at cycle 2; wb_regwrite_o=1, wb_memtoreg_o=1, wb_rd_o=5 at cycle 3.
- Load-use: lw x5; then add x6,x5,x7 -> stall_o=1 for exactly one cycle, bubble in EX; next cycle add enters EX with forward_a_o=01. Repeat with HAZARD_EN=0 -> stall_o stays 0.
- Forwarding: add x3,x1,x2; addi x4,x3,1; sub x8,x3,x3 -> addi sees forward_a_o=10; sub sees forward_a_o=forward_b_o=01. A write to x0 followed by a read of x0 -> 00.
- Flush priority: branch_taken_i=1 in the same cycle a load-use condition exists -> flush_o=1, stall_o=0, ID/EX bubble on the next edge.
- Illegal/branches: opcode 1111111 -> all-zero bundle, illegal_o=1 for one cycle. beq -> ex_branch_o=1, ex_bne_o=0. bne -> ex_bne_o=1. Branch with funct3=100 -> illegal_o=1, ex_branch_o=0.
